// File: rtl/bram_stream_reader.sv
// bram_stream_reader
// Read-side controller for a simple dual-port BRAM. Walks a contiguous
// (wrapping) address range on port B, absorbs the RAM's one-cycle read
// latency and presents the returned words as a valid/ready stream through
// a two-entry output buffer. The final word of a transfer is tagged with
// m_last and normal completion is reported with a one-cycle done pulse.

module bram_stream_reader #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 36
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   len,
  input  logic                  abort,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] addr_B,
  output logic                  ren_B,
  input  logic [DATA_WIDTH-1:0] dout_B,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  m_last
);

  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = 1;
  localparam logic [ADDR_WIDTH:0]   CNT_ONE  = 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FLUSH
  } state_t;

  state_t state;

  // Transfer bookkeeping
  logic [ADDR_WIDTH:0]   len_q;
  logic [ADDR_WIDTH:0]   issued;
  logic [ADDR_WIDTH-1:0] next_addr;
  logic [ADDR_WIDTH-1:0] last_addr;

  // A read launched last cycle whose data is on dout_B this cycle
  logic inflight;
  logic inflight_last;

  // Two-entry output buffer
  logic [DATA_WIDTH-1:0] buf_data [2];
  logic [1:0]            buf_last;
  logic                  rd_ptr;
  logic                  wr_ptr;
  logic [1:0]            count;

  // Per-cycle control terms
  logic       run_ok;
  logic       pop;
  logic       push;
  logic       issue;
  logic       is_last_issue;
  logic [2:0] pending;

  // Issue/accept decisions; a pop frees a slot in the same cycle so a full
  // pipeline keeps one word per cycle flowing under continuous m_ready.
  always_comb begin
    run_ok        = (state == RUN) && !abort;
    m_valid       = (count != 2'd0);
    m_data        = buf_data[rd_ptr];
    m_last        = m_valid && buf_last[rd_ptr];
    pop           = run_ok && m_valid && m_ready;
    push          = run_ok && inflight;
    pending       = {1'b0, count} + {2'b00, inflight};
    is_last_issue = (issued == (len_q - CNT_ONE));
    issue         = run_ok && (issued < len_q) && ((pending < 3'd2) || pop);
    ren_B         = issue;
    addr_B        = issue ? next_addr : last_addr;
  end

  // Control FSM with transfer counters and registered busy/done.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      busy          <= 1'b0;
      done          <= 1'b0;
      len_q         <= '0;
      issued        <= '0;
      next_addr     <= '0;
      last_addr     <= '0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
    end else begin
      done          <= 1'b0;
      inflight      <= issue;
      inflight_last <= issue && is_last_issue;

      if (issue) begin
        last_addr <= next_addr;
        next_addr <= next_addr + ADDR_ONE;
        issued    <= issued + CNT_ONE;
      end

      case (state)
        IDLE: begin
          if (start) begin
            if (len == '0) begin
              done <= 1'b1;
            end else begin
              state     <= RUN;
              busy      <= 1'b1;
              len_q     <= len;
              issued    <= '0;
              next_addr <= base_addr;
            end
          end
        end
        RUN: begin
          if (abort) begin
            state <= FLUSH;
          end else if (pop && m_last) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        FLUSH: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // Output buffer: capture returning RAM words, release them on handshake,
  // and drop everything when a transfer is cancelled.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr   <= 1'b0;
      wr_ptr   <= 1'b0;
      count    <= 2'd0;
      buf_last <= 2'b00;
      for (int i = 0; i < 2; i++) begin
        buf_data[i] <= '0;
      end
    end else if (((state == RUN) && abort) || (state == FLUSH)) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        buf_data[wr_ptr] <= dout_B;
        buf_last[wr_ptr] <= inflight_last;
        wr_ptr           <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_bram_stream_reader.sv
// tb_bram_stream_reader
// Scoreboard bench: each start pushes the expected words and read addresses
// into queues; a negedge monitor pops and compares them as the DUT issues
// reads and completes handshakes, and also watches stall stability and the
// outstanding-word bound.

module tb_bram_stream_reader;

  logic        clk;
  logic        rst;
  logic        start;
  logic [9:0]  base_addr;
  logic [10:0] len;
  logic        abort;
  logic        busy;
  logic        done;
  logic [9:0]  addr_B;
  logic        ren_B;
  logic [35:0] dout_B;
  logic [35:0] m_data;
  logic        m_valid;
  logic        m_ready;
  logic        m_last;

  bram_stream_reader #(
    .ADDR_WIDTH(10),
    .DATA_WIDTH(36)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .base_addr(base_addr),
    .len      (len),
    .abort    (abort),
    .busy     (busy),
    .done     (done),
    .addr_B   (addr_B),
    .ren_B    (ren_B),
    .dout_B   (dout_B),
    .m_data   (m_data),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .m_last   (m_last)
  );

  logic [35:0] ram [1024];
  logic [36:0] exp_q [$];
  logic [9:0]  addr_q [$];

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;
  int start_cyc   = 0;
  int beat_n      = 0;
  int first_hs_cyc = -1;
  int last_hs_cyc  = -1;
  int total_reads = 0;
  int total_hs    = 0;
  bit prev_stall  = 1'b0;
  logic [35:0] prev_data;
  logic        prev_last;

  // Free-running clock and cycle index
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous-read RAM model behind port B
  always @(posedge clk) begin
    if (ren_B) dout_B <= ram[addr_B];
  end

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Start a transfer and queue its expected addresses and words
  task automatic applyStimulus(input int b, input int l);
    int a;
    base_addr = 10'(b);
    len       = 11'(l);
    start     = 1'b1;
    beat_n       = 0;
    first_hs_cyc = -1;
    last_hs_cyc  = -1;
    for (int i = 0; i < l; i++) begin
      a = (b + i) % 1024;
      exp_q.push_back({(i == l - 1), 36'(a * 3)});
      addr_q.push_back(10'(a));
    end
    @(posedge clk);
    #1;
    start     = 1'b0;
    start_cyc = cyc;
  endtask

  // Wait (bounded) for done, optionally randomising m_ready each cycle
  task automatic waitDone(input int budget, input bit rand_ready);
    bit got;
    got = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk);
      #1;
      if (done) begin
        got = 1'b1;
        break;
      end
      if (rand_ready) m_ready = 1'($urandom_range(0, 1));
    end
    checkOutput("done_seen", got, 1);
    if (got) begin
      checkOutput("done_after_last", cyc, last_hs_cyc + 1);
      checkOutput("busy_at_done", busy, 0);
      checkOutput("drained", exp_q.size(), 0);
      m_ready = 1'b1;
      @(posedge clk);
      #1;
      checkOutput("done_pulse", done, 0);
    end
    m_ready = 1'b1;
  endtask

  // Monitor: sample half a cycle away from the active edge
  always @(negedge clk) begin
    logic [36:0] e;
    if (!rst) begin
      prev_stall = 1'b0;
    end else begin
      if (busy) checkOutput("occ_le2", ((total_reads - total_hs) <= 2), 1);
      if (prev_stall) begin
        checkOutput("stall_valid", m_valid, 1);
        checkOutput("stall_data", m_data, prev_data);
        checkOutput("stall_last", m_last, prev_last);
      end
      if (ren_B) begin
        total_reads++;
        if (addr_q.size() == 0) checkOutput("addr_extra", 1, 0);
        else checkOutput("addr", addr_B, addr_q.pop_front());
      end
      if (m_valid && m_ready && !abort) begin
        total_hs++;
        beat_n++;
        if (first_hs_cyc < 0) first_hs_cyc = cyc;
        last_hs_cyc = cyc;
        if (exp_q.size() == 0) begin
          checkOutput("beat_extra", 1, 0);
        end else begin
          e = exp_q.pop_front();
          checkOutput("data", m_data, e[35:0]);
          checkOutput("last", m_last, e[36]);
        end
      end
      prev_stall = m_valid && !m_ready && !abort;
      prev_data  = m_data;
      prev_last  = m_last;
    end
  end

  // Global time limit
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] simulation time limit");
  end

  initial begin
    for (int a = 0; a < 1024; a++) ram[a] = 36'(a * 3);
    dout_B    = '0;
    rst       = 1'b0;
    start     = 1'b0;
    base_addr = '0;
    len       = '0;
    abort     = 1'b0;
    m_ready   = 1'b1;

    // Reset state
    #2;
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_ren", ren_B, 0);
    checkOutput("rst_valid", m_valid, 0);
    checkOutput("rst_last", m_last, 0);
    checkOutput("rst_addr", addr_B, 0);
    checkOutput("rst_data", m_data, 0);
    #10;
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Full-depth streaming at one word per cycle
    $display("[TB] full sweep base=0 len=1024");
    applyStimulus(0, 1024);
    @(negedge clk);
    checkOutput("lat_ren", ren_B, 1);
    checkOutput("lat_busy", busy, 1);
    @(negedge clk);
    checkOutput("lat_novalid", m_valid, 0);
    waitDone(1200, 1'b0);
    checkOutput("first_beat_cyc", first_hs_cyc, start_cyc + 2);
    checkOutput("beats_1024", beat_n, 1024);
    checkOutput("no_bubbles", last_hs_cyc - first_hs_cyc, 1023);

    // Address wrap past the top of the RAM
    $display("[TB] wrap base=1020 len=8");
    applyStimulus(1020, 8);
    waitDone(50, 1'b0);
    checkOutput("wrap_beats", beat_n, 8);

    // Backpressure: hold off after the first beat, then random ready
    $display("[TB] backpressure len=16");
    applyStimulus(200, 16);
    for (int i = 0; i < 20; i++) begin
      if (beat_n >= 1) break;
      @(posedge clk);
      #1;
    end
    checkOutput("bp_first_beat", beat_n, 1);
    m_ready = 1'b0;
    repeat (4) @(posedge clk);
    waitDone(2000, 1'b1);
    checkOutput("bp_beats", beat_n, 16);

    // Zero-length start
    $display("[TB] len=0 start");
    applyStimulus(0, 0);
    @(negedge clk);
    checkOutput("len0_done", done, 1);
    checkOutput("len0_busy", busy, 0);
    checkOutput("len0_ren", ren_B, 0);
    checkOutput("len0_valid", m_valid, 0);
    @(negedge clk);
    checkOutput("len0_done_end", done, 0);
    checkOutput("len0_busy2", busy, 0);
    @(posedge clk);
    #1;

    // Abort after ten accepted beats
    $display("[TB] abort len=100");
    applyStimulus(0, 100);
    for (int i = 0; i < 100; i++) begin
      if (beat_n >= 10) break;
      @(posedge clk);
      #1;
    end
    checkOutput("abort_beats", beat_n, 10);
    abort = 1'b1;
    @(negedge clk);
    checkOutput("abort_ren", ren_B, 0);
    checkOutput("abort_nodone0", done, 0);
    @(posedge clk);
    #1;
    abort = 1'b0;
    exp_q.delete();
    addr_q.delete();
    total_reads = 0;
    total_hs    = 0;
    @(negedge clk);
    checkOutput("abort_mvalid", m_valid, 0);
    checkOutput("flush_busy", busy, 1);
    checkOutput("abort_nodone1", done, 0);
    @(negedge clk);
    checkOutput("abort_busy", busy, 0);
    checkOutput("abort_nodone2", done, 0);
    @(posedge clk);
    #1;
    applyStimulus(5, 2);
    waitDone(50, 1'b0);
    checkOutput("post_abort_beats", beat_n, 2);

    // Asynchronous reset in the middle of a transfer
    $display("[TB] async reset mid-transfer");
    applyStimulus(0, 50);
    repeat (5) @(posedge clk);
    #3;
    checkOutput("pre_rst_valid", m_valid, 1);
    rst = 1'b0;
    #1;
    checkOutput("arst_valid", m_valid, 0);
    checkOutput("arst_ren", ren_B, 0);
    checkOutput("arst_busy", busy, 0);
    exp_q.delete();
    addr_q.delete();
    total_reads = 0;
    total_hs    = 0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    checkOutput("arst_nodone", done, 0);
    checkOutput("arst_idle", busy, 0);
    @(posedge clk);
    #1;
    applyStimulus(0, 4);
    waitDone(50, 1'b0);
    checkOutput("post_rst_beats", beat_n, 4);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/bram_stream_reader.md
Name: bram_stream_reader

Overview:
- Read-side controller for the 36-bit simple dual-port BRAM. It drives the read port (addr_B/ren_B) and absorbs the RAM's 1-cycle read latency.
- Returned words are presented as a valid/ready stream with a 2-entry output buffer.
- It is the consumer counterpart to the write-port producer: a block deposits a frame through port A, and this block streams it back out.

Parameters:
- ADDR_WIDTH, 10, RAM address width; depth = 2**ADDR_WIDTH.
- DATA_WIDTH, 36, RAM word width.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  begin a transfer; sampled only in IDLE.
- base_addr  in  ADDR_WIDTH  first RAM address, sampled with start.
- len  in  ADDR_WIDTH+1  word count, 0..2**ADDR_WIDTH, sampled with start.
- abort  in  1  synchronous transfer cancel.
- busy  out  1  transfer in progress (RUN or FLUSH).
- done  out  1  one-cycle pulse on normal completion.
- addr_B  out  ADDR_WIDTH  RAM read address.
- ren_B  out  1  RAM read enable.
- dout_B  in  DATA_WIDTH  RAM read data, valid the cycle after ren_B was high.
- m_data  out  DATA_WIDTH  stream data.
- m_valid  out  1  stream valid.
- m_ready  in  1  stream ready.
- m_last  out  1  marks the final word of the transfer.

Behaviour:
- Reset (rst low, asynchronous, no clock needed):
  - busy, done, ren_B, m_valid, m_last = 0.
  - addr_B, m_data = 0.
  - Buffer empty, state IDLE.
- States:
  - IDLE: on start with len>0, go to RUN. Latch base_addr, remaining=len, issued=0.
  - IDLE: on start with len=0, stay in IDLE and pulse done the next cycle. No reads are issued and busy stays 0.
  - RUN: issue reads and drain the buffer. After the handshake of the word carrying m_last, return to IDLE and pulse done in the following cycle.
  - RUN: on abort, go to FLUSH.
  - FLUSH: lasts exactly 1 cycle and discards any in-flight RAM word, then goes to IDLE. done is not pulsed.
- start is ignored while busy.
- busy = 1 in RUN and FLUSH, and 0 in the cycle done is high.
- Read issue:
  - ren_B=1 when state is RUN, no abort, issued<len, and (occupancy + inflight) < 2, or the buffer is popped this cycle.
  - ren_B may depend combinationally on m_ready.
  - inflight = 1 in the cycle after a read is issued.
  - Invariant: occupancy + inflight <= 2. The bench checks this every cycle.
- Addressing:
  - addr_B = (base_addr + issued) mod 2**ADDR_WIDTH, wrapping past the top address to 0.
  - addr_B holds its last value while ren_B=0.
- Latency and throughput:
  - First m_valid is 2 cycles after the start edge: issue in cycle 1, data captured in cycle 2.
  - With m_ready held high, throughput is 1 word per cycle with no bubbles.
- Buffer:
  - 2-entry FIFO. The returned dout_B is written on the cycle after ren_B.
  - Simultaneous push and pop is allowed at any occupancy.
  - Words are delivered in address order.
  - m_data and m_last stay stable while m_valid=1 and m_ready=0.
- m_last is high only on word number len-1 (counting from 0).
- Abort:
  - Issuing stops in the same cycle: ren_B is forced to 0.
  - At the next edge the buffer is emptied and m_valid drops to 0.
  - No handshake is accepted in the abort cycle.
- Reset asserted mid-transfer: immediate return to the reset state. Partial data is lost and done is not pulsed.

Test Plan:
- Preload RAM[a]=a*3 (a=0..1023). start with base=0, len=1024, m_ready=1 held high.
  -> 1024 beats with m_data=3*i, one per cycle, first beat 2 cycles after start.
  -> m_last on beat 1023, done pulse one cycle later, busy low at that point.
- Wrap-around: base=1020, len=8.
  -> addr_B sequence 1020,1021,1022,1023,0,1,2,3.
  -> m_data 3060,3063,3066,3069,0,3,6,9; m_last on the 8th beat.
- Backpressure: len=16, m_ready low for 5 cycles after the first beat, then random.
  -> 16 beats with no loss or duplication, m_data stable during stalls, occupancy+inflight never above 2.
- len=0 start.
  -> done high exactly 1 cycle after start; ren_B, m_valid and busy stay 0.
- Abort after 10 accepted beats of a len=100 transfer.
  -> ren_B low that cycle, m_valid low the next cycle, busy low 2 cycles after abort, no done.
  -> A new start with base=5, len=2 then yields 15,18.
- Async reset asserted mid-transfer between clock edges.
  -> m_valid, ren_B and busy drop to 0 immediately.
  -> After release, a new start with base=0, len=4 yields 0,3,6,9.
